// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - instruction sequencer that decodes, issues to and writes back from an external ALU
// Optional result flags are built only when ALU_SEQ_FLAGS_EN is defined.
module alu_seq #(
  parameter int NREGS = 8,
  parameter int W     = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         instr_valid,
  output logic         instr_ready,
  input  logic [15:0]  instr,
  output logic         alu_en,
  output logic [3:0]   alu_oper,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  input  logic [W-1:0] alu_q,
  output logic         done,
  output logic         illegal,
  input  logic         err_clr,
  input  logic [2:0]   rd_sel,
  output logic [W-1:0] rd_data,
  output logic         flag_z,
  output logic         flag_n
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPT} state_t;

  state_t       state_q, state_d;
  logic [15:0]  instr_q, instr_d;
  logic [W-1:0] rf_q [NREGS];
  logic [W-1:0] rf_d [NREGS];
  logic         alu_en_q, alu_en_d;
  logic [3:0]   alu_oper_q, alu_oper_d;
  logic [W-1:0] alu_a_q, alu_a_d;
  logic [W-1:0] alu_b_q, alu_b_d;
  logic         done_q, done_d;
  logic         illegal_q, illegal_d;
  logic         illegal_set;
  logic [3:0]   op_in;
  logic [W-1:0] wr_data;

  assign op_in = instr[15:12];

  // LDI writes its zero-extended 9-bit immediate instead of the ALU result
  assign wr_data = (instr_q[15:12] == 4'd12) ? {{(W-9){1'b0}}, instr_q[8:0]} : alu_q;

  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    rf_d        = rf_q;
    alu_en_d    = 1'b0;
    alu_oper_d  = 4'd0;
    alu_a_d     = '0;
    alu_b_d     = '0;
    done_d      = 1'b0;
    illegal_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (instr_valid) begin
          instr_d = instr;
          if (op_in >= 4'd1 && op_in <= 4'd11) begin
            state_d    = ISSUE;
            alu_en_d   = 1'b1;
            alu_oper_d = op_in;
            alu_a_d    = rf_q[instr[8:6]];
            alu_b_d    = rf_q[instr[5:3]];
          end else if (op_in == 4'd12) begin
            state_d = ISSUE;
          end else begin
            done_d      = 1'b1;
            illegal_set = (op_in >= 4'd13);
          end
        end
      end
      ISSUE: begin
        state_d = CAPT;
      end
      CAPT: begin
        rf_d[instr_q[11:9]] = wr_data;
        done_d              = 1'b1;
        state_d             = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    illegal_d = illegal_set ? 1'b1 : (err_clr ? 1'b0 : illegal_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      instr_q    <= '0;
      alu_en_q   <= 1'b0;
      alu_oper_q <= 4'd0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      done_q     <= 1'b0;
      illegal_q  <= 1'b0;
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      alu_en_q   <= alu_en_d;
      alu_oper_q <= alu_oper_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      done_q     <= done_d;
      illegal_q  <= illegal_d;
      rf_q       <= rf_d;
    end
  end

  assign instr_ready = (state_q == IDLE);
  assign alu_en      = alu_en_q;
  assign alu_oper    = alu_oper_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign done        = done_q;
  assign illegal     = illegal_q;
  assign rd_data     = rf_q[rd_sel];

`ifdef ALU_SEQ_FLAGS_EN
  logic flag_z_q, flag_z_d;
  logic flag_n_q, flag_n_d;

  always_comb begin
    flag_z_d = flag_z_q;
    flag_n_d = flag_n_q;
    if (state_q == CAPT) begin
      flag_z_d = (wr_data == '0);
      flag_n_d = wr_data[W-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_z_q <= 1'b0;
      flag_n_q <= 1'b0;
    end else begin
      flag_z_q <= flag_z_d;
      flag_n_q <= flag_n_d;
    end
  end

  assign flag_z = flag_z_q;
  assign flag_n = flag_n_q;
`else
  assign flag_z = 1'b0;
  assign flag_n = 1'b0;
`endif

endmodule
